serial_work_sender: RTL
=======================

Name: serial_work_sender

Overview:
- UART-side transmitter that emits one mining work unit (256-bit midstate + 256-bit data2) as a 64-byte 8N1 frame on TxD.
- The byte layout is the exact format serial_receive consumes, so this block is the sending end of the miner's work link.
- Used on the host-bridge FPGA and in loopback benches that drive fpgaminer_top's RxD.
- Single clock domain; the work is latched on a load pulse and serialised autonomously.

Parameters:
- CLK_FREQ, 109000000, clk frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DIV (localparam), (CLK_FREQ + BAUD/2) / BAUD, clk cycles per UART bit. Must be >= 2; elaboration fails otherwise.

Ports:
- clk  in  1  Single clock; reset is synchronous and active-high.
- reset  in  1  Synchronous, active-high.
- load  in  1  One-cycle request to send midstate/data2. Honoured only when busy=0.
- midstate  in  256  Work midstate; sampled on an accepted load.
- data2  in  256  Work tail (nonce-less header words); sampled on an accepted load.
- TxD  out  1  UART line, idle high.
- busy  out  1  High from the cycle after an accepted load until the frame ends.
- done  out  1  One-cycle pulse when the last stop bit completes.

Behaviour:
- Reset values: TxD=1, busy=0, done=0, FSM=IDLE, bit counter=0, byte counter=0, baud counter=0.
- Frame content: a 512-bit shift register is loaded with {midstate, data2}.
  - Bytes go out least-significant byte first: byte0 = data2[7:0], byte31 = data2[255:248], byte32 = midstate[7:0], byte63 = midstate[255:248].
  - Bits within a byte go LSB first.
- Byte format: 1 start bit (0), 8 data bits, 1 stop bit (1). Each bit holds TxD for exactly DIV clk cycles.
- No idle gap between bytes: the next start bit follows the previous stop bit immediately.
- FSM states:
  - IDLE: TxD=1. A load with busy=0 captures the inputs and moves to START on the next edge; busy rises on that same edge.
  - START: TxD=0 for DIV cycles, then DATA.
  - DATA: 8 bits, DIV cycles each, then STOP.
  - STOP: TxD=1 for DIV cycles. If bytes remain, go to START; otherwise go to IDLE, with done=1 and busy=0 in the first IDLE cycle.
- Latency: load accepted at edge N gives TxD=0 from edge N+1. The whole frame is 640*DIV cycles; done asserts at edge N+1+640*DIV.
- Counters:
  - Baud counter is 0..DIV-1, width clog2(DIV).
  - Byte counter is 0..63 (6 bits). Terminal count is 63, plus 1 with the optional feature enabled; wrap is never used.
- Load while busy=1: ignored. Captured data is unchanged and no queueing occurs.
- Load in the same cycle done=1: accepted, since busy is already 0. Back-to-back frames are separated by exactly 1 idle-high cycle.
- Reset mid-frame: on the next edge TxD=1, busy=0, done=0, and the frame is abandoned.
  - The receiver sees a truncated frame; recovering from that is the receiver's concern.
- Reset and load in the same cycle: reset wins and the load is dropped.
- Inputs midstate/data2 may change freely after the accepting edge.

Optional Feature:
- Macro: SERIAL_WORK_CHECKSUM_EN.
- Defined:
  - A 65th byte is appended: the XOR of all 64 payload bytes.
  - It is accumulated while shifting and sent in the same 8N1 format.
  - Frame length becomes 650*DIV cycles, and done moves accordingly.
- Undefined:
  - Exactly 64 bytes are sent.
  - No checksum logic is synthesised.

Test Plan:
- Reset then idle (DIV=16 via CLK_FREQ=16, BAUD=1): hold 100 cycles -> TxD=1, busy=0, done=0 throughout.
- Single frame with midstate=256'h0, data2=256'hA5 in byte0, rest 0:
  - UART monitor decodes byte0=8'hA5, then 63 bytes of 8'h00.
  - TxD low 16 cycles after load+1.
  - done pulses exactly once, 10241 cycles after the load edge.
- Full pattern with midstate byte k = 8'h20+k and data2 byte k = 8'h00+k:
  - Decoded stream is 00..1F, 20..3F.
  - Stream matches the 512-bit value serial_receive reconstructs (loopback into serial_receive: midstate and data2 equal the inputs, rx_done asserts).
- Busy protection: second load with different data at cycles 50 and 5000 after the first -> stream unchanged, only one done.
- Back-to-back: load asserted on the done cycle -> second frame starts after 1 idle cycle with correct content.
- Reset at cycle 3000 mid-frame, then a load of the pattern frame:
  - TxD=1 the next cycle.
  - No done from the aborted frame.
  - The new frame decodes correctly.
  - With SERIAL_WORK_CHECKSUM_EN defined, the pattern frame carries 65th byte 8'h00, the XOR of 00..3F.

Source files
------------

// File: rtl/serial_work_sender.sv
// serial_work_sender: sends {midstate,data2} LSB-byte-first as 64 8N1 bytes on TxD (SERIAL_WORK_CHECKSUM_EN appends an XOR byte)
module serial_work_sender #(
  parameter int CLK_FREQ = 109000000,
  parameter int BAUD = 115200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [255:0] midstate,
  input  logic [255:0] data2,
  output logic         TxD,
  output logic         busy,
  output logic         done
);
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef SERIAL_WORK_CHECKSUM_EN
  localparam int NB = 7;
  localparam int LAST = 64;
`else
  localparam int NB = 6;
  localparam int LAST = 63;
`endif
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  if (DIV < 2) begin : g_div_chk
    $error("serial_work_sender: DIV must be >= 2");
  end
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [NB-1:0] byte_q, byte_d;
  logic [511:0]  sh_q, sh_d;
  logic          tx_d, busy_d, done_d, baud_end;
`ifdef SERIAL_WORK_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif
  always_comb begin
    baud_end = baud_q == BW'(DIV - 1);
    state_d = state_q;
    baud_d = baud_q;
    bit_d = bit_q;
    byte_d = byte_q;
    sh_d = sh_q;
    busy_d = busy;
    done_d = 1'b0;
`ifdef SERIAL_WORK_CHECKSUM_EN
    csum_d = csum_q;
`endif
    if (state_q == IDLE) begin
      if (load) begin
        state_d = START;
        sh_d = {midstate, data2};
        busy_d = 1'b1;
        baud_d = '0;
        bit_d = '0;
        byte_d = '0;
`ifdef SERIAL_WORK_CHECKSUM_EN
        csum_d = '0;
`endif
      end
    end else begin
      baud_d = baud_end ? '0 : baud_q + BW'(1);
      if (baud_end) begin
        if (state_q == START) begin
          state_d = DATA;
`ifdef SERIAL_WORK_CHECKSUM_EN
          csum_d = csum_q ^ sh_q[7:0];
`endif
        end else if (state_q == DATA) begin
          sh_d = sh_q >> 1;
          bit_d = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? STOP : DATA;
        end else if (byte_q == NB'(LAST)) begin
          state_d = IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          state_d = START;
          byte_d = byte_q + NB'(1);
`ifdef SERIAL_WORK_CHECKSUM_EN
          if (byte_q == NB'(63)) sh_d = {504'd0, csum_q};
`endif
        end
      end
    end
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      sh_q <= '0;
      TxD <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef SERIAL_WORK_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      sh_q <= sh_d;
      TxD <= tx_d;
      busy <= busy_d;
      done <= done_d;
`ifdef SERIAL_WORK_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
endmodule
